// File: rtl/gol_pkg.sv
// Shared constants, state encoding and address helper for the Game of Life
// generation sequencer.
package gol_pkg;

  localparam int WORD_W              = 16;
  localparam int ADDR_W              = 11;
  localparam int OFF_W               = 10;
  localparam int BANK_OFFSET_DEFAULT = 1024;

  // Sequencer states: three window reads, window shift, write-back, bank swap.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_N  = 3'd1,
    ST_RD_C  = 3'd2,
    ST_RD_S  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_WR    = 3'd5,
    ST_SWAP  = 3'd6
  } state_t;

  // Which row of the incoming column a pending read belongs to.
  typedef enum logic [1:0] {
    SLOT_N = 2'd0,
    SLOT_C = 2'd1,
    SLOT_S = 2'd2
  } slot_t;

  // Physical RAM word address of a word offset inside bank 0 or bank 1.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic              bank,
    input logic [OFF_W-1:0]  off,
    input logic [ADDR_W-1:0] bank_base
  );
    word_addr = (bank ? bank_base : {ADDR_W{1'b0}}) + ADDR_W'(off);
  endfunction

endpackage

// File: rtl/gol_word_rule.sv
// Applies the Life rule to 16 horizontally adjacent cells. Each input row
// carries the left neighbour cell in bit 0, the 16 word cells in bits 16:1
// and the right neighbour cell in bit 17.
module gol_word_rule
  import gol_pkg::*;
(
  input  logic [WORD_W+1:0] row_n,
  input  logic [WORD_W+1:0] row_c,
  input  logic [WORD_W+1:0] row_s,
  output logic [WORD_W-1:0] next_cells
);

  logic [3:0] cnt_s;

  // Count the eight neighbours of every cell and decide survival or birth.
  always_comb begin
    next_cells = {WORD_W{1'b0}};
    cnt_s      = 4'd0;
    for (int i = 0; i < WORD_W; i++) begin
      cnt_s = 4'(row_n[i]) + 4'(row_n[i+1]) + 4'(row_n[i+2])
            + 4'(row_c[i])                  + 4'(row_c[i+2])
            + 4'(row_s[i]) + 4'(row_s[i+1]) + 4'(row_s[i+2]);
      if (cnt_s == 4'd3) begin
        next_cells[i] = 1'b1;
      end else if (cnt_s == 4'd2) begin
        next_cells[i] = row_c[i+1];
      end else begin
        next_cells[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gol_generation_sequencer.sv
// Computes one Game of Life generation over a ping-pong banked word RAM.
// Port A reads the 3x3 word window (shared with a display reader that always
// wins), port B writes the next generation into the other bank or accepts
// host seed words while idle.
module gol_generation_sequencer
  import gol_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int HEIGHT      = 32,
  parameter int BANK_OFFSET = BANK_OFFSET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              get_next,
  output logic              busy,
  output logic              done,
  output logic              cur_bank,
  input  logic              disp_req,
  input  logic [OFF_W-1:0]  disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [WORD_W-1:0] disp_data,
  input  logic              load_we,
  input  logic [OFF_W-1:0]  load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [WORD_W-1:0] dia,
  input  logic [WORD_W-1:0] doa,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [WORD_W-1:0] dib
);

  localparam int                WPR     = WIDTH / WORD_W;
  localparam logic [OFF_W-1:0]  WPR_L   = OFF_W'(WPR);
  localparam logic [OFF_W-1:0]  Y_LAST  = OFF_W'(HEIGHT - 1);
  localparam logic [OFF_W-1:0]  ONE_OFF = OFF_W'(1);
  localparam logic [ADDR_W-1:0] BASE1   = ADDR_W'(BANK_OFFSET);

  // Sequencer state and counters
  state_t                 state_r;
  logic [OFF_W-1:0]       y_r;
  logic [OFF_W-1:0]       c_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   bank_r;
  logic                   disp_valid_r;

  // Read pipeline: a read issued this cycle lands in doa next cycle
  logic                   pend_r;
  logic                   pend_en_r;
  slot_t                  pend_slot_r;
  logic [WORD_W-1:0]      cap_n_r;
  logic [WORD_W-1:0]      cap_c_r;

  // Column window: only the right-most cell of the left column matters
  logic [2:0]             prev_edge_r;
  logic [2:0][WORD_W-1:0] cur_r;
  logic [2:0][WORD_W-1:0] new_r;

  // Combinational helpers
  logic                   rd_active_s;
  logic                   rd_in_grid_s;
  slot_t                  rd_slot_s;
  logic [OFF_W-1:0]       rd_row_s;
  logic [OFF_W-1:0]       rd_off_s;
  logic [OFF_W-1:0]       wr_off_s;
  logic                   seq_issue_s;
  logic                   seq_rd_en_s;
  logic [WORD_W-1:0]      cap_val_s;
  logic [WORD_W+1:0]      row_n_s;
  logic [WORD_W+1:0]      row_c_s;
  logic [WORD_W+1:0]      row_s_s;
  logic [WORD_W-1:0]      rule_out_s;

  // Select the row the current read state fetches and whether it lies inside the grid.
  always_comb begin
    rd_active_s  = 1'b0;
    rd_in_grid_s = 1'b0;
    rd_slot_s    = SLOT_N;
    rd_row_s     = y_r;
    case (state_r)
      ST_RD_N: begin
        rd_active_s  = 1'b1;
        rd_slot_s    = SLOT_N;
        rd_row_s     = y_r - ONE_OFF;
        rd_in_grid_s = (y_r != {OFF_W{1'b0}});
      end
      ST_RD_C: begin
        rd_active_s  = 1'b1;
        rd_slot_s    = SLOT_C;
        rd_row_s     = y_r;
        rd_in_grid_s = 1'b1;
      end
      ST_RD_S: begin
        rd_active_s  = 1'b1;
        rd_slot_s    = SLOT_S;
        rd_row_s     = y_r + ONE_OFF;
        rd_in_grid_s = (y_r != Y_LAST);
      end
      default: begin
        rd_active_s  = 1'b0;
        rd_in_grid_s = 1'b0;
        rd_slot_s    = SLOT_N;
        rd_row_s     = y_r;
      end
    endcase
  end

  // A read slot proceeds only when the display is not using port A; the
  // column one past the right edge is read as all-dead without touching RAM.
  assign seq_issue_s = rd_active_s & ~disp_req;
  assign seq_rd_en_s = seq_issue_s & rd_in_grid_s & (c_r != WPR_L);
  assign rd_off_s    = rd_row_s * WPR_L + c_r;
  assign wr_off_s    = y_r * WPR_L + c_r - ONE_OFF;
  assign cap_val_s   = pend_en_r ? doa : {WORD_W{1'b0}};

  // Rows for the rule: left edge from the previous column, right edge from the new one.
  assign row_n_s = {new_r[0][0], cur_r[0], prev_edge_r[0]};
  assign row_c_s = {new_r[1][0], cur_r[1], prev_edge_r[1]};
  assign row_s_s = {new_r[2][0], cur_r[2], prev_edge_r[2]};

  gol_word_rule u_rule (
    .row_n      (row_n_s),
    .row_c      (row_c_s),
    .row_s      (row_s_s),
    .next_cells (rule_out_s)
  );

  // Port A arbitration: display read has absolute priority over the sequencer.
  always_comb begin
    if (disp_req) begin
      ena   = 1'b1;
      addra = word_addr(bank_r, disp_addr, BASE1);
    end else begin
      ena   = seq_rd_en_s;
      addra = word_addr(bank_r, rd_off_s, BASE1);
    end
  end

  assign wea      = 1'b0;
  assign dia      = {WORD_W{1'b0}};
  assign disp_gnt = disp_req;

  // Port B: host seed writes while idle, next-generation writes in WR.
  always_comb begin
    enb   = 1'b0;
    web   = 1'b0;
    addrb = word_addr(bank_r, load_addr, BASE1);
    dib   = load_data;
    if (state_r == ST_IDLE) begin
      enb   = load_we;
      web   = load_we;
      addrb = word_addr(bank_r, load_addr, BASE1);
      dib   = load_data;
    end else if ((state_r == ST_WR) && (c_r != {OFF_W{1'b0}})) begin
      enb   = 1'b1;
      web   = 1'b1;
      addrb = word_addr(~bank_r, wr_off_s, BASE1);
      dib   = rule_out_s;
    end else begin
      enb   = 1'b0;
      web   = 1'b0;
    end
  end

  // Generation FSM with read capture, window shifting and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      y_r          <= {OFF_W{1'b0}};
      c_r          <= {OFF_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      bank_r       <= 1'b0;
      disp_valid_r <= 1'b0;
      pend_r       <= 1'b0;
      pend_en_r    <= 1'b0;
      pend_slot_r  <= SLOT_N;
      cap_n_r      <= {WORD_W{1'b0}};
      cap_c_r      <= {WORD_W{1'b0}};
      prev_edge_r  <= 3'b000;
      cur_r        <= {(3*WORD_W){1'b0}};
      new_r        <= {(3*WORD_W){1'b0}};
    end else begin
      disp_valid_r <= disp_req;
      pend_r       <= seq_issue_s;
      pend_en_r    <= seq_rd_en_s;
      pend_slot_r  <= rd_slot_s;

      // The south word is consumed directly by SHIFT, so only N and C are held.
      if (pend_r) begin
        case (pend_slot_r)
          SLOT_N:  cap_n_r <= cap_val_s;
          SLOT_C:  cap_c_r <= cap_val_s;
          default: cap_c_r <= cap_c_r;
        endcase
      end

      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (get_next) begin
            state_r     <= ST_RD_N;
            busy_r      <= 1'b1;
            y_r         <= {OFF_W{1'b0}};
            c_r         <= {OFF_W{1'b0}};
            prev_edge_r <= 3'b000;
            cur_r       <= {(3*WORD_W){1'b0}};
            new_r       <= {(3*WORD_W){1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_N: begin
          state_r <= disp_req ? ST_RD_N : ST_RD_C;
        end
        ST_RD_C: begin
          state_r <= disp_req ? ST_RD_C : ST_RD_S;
        end
        ST_RD_S: begin
          state_r <= disp_req ? ST_RD_S : ST_SHIFT;
        end
        ST_SHIFT: begin
          prev_edge_r <= {cur_r[2][WORD_W-1], cur_r[1][WORD_W-1], cur_r[0][WORD_W-1]};
          cur_r       <= new_r;
          new_r       <= {cap_val_s, cap_c_r, cap_n_r};
          state_r     <= ST_WR;
        end
        ST_WR: begin
          if (c_r == WPR_L) begin
            c_r <= {OFF_W{1'b0}};
            if (y_r == Y_LAST) begin
              state_r <= ST_SWAP;
              done_r  <= 1'b1;
            end else begin
              y_r     <= y_r + ONE_OFF;
              state_r <= ST_RD_N;
            end
          end else begin
            c_r     <= c_r + ONE_OFF;
            state_r <= ST_RD_N;
          end
        end
        ST_SWAP: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          bank_r  <= ~bank_r;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign cur_bank   = bank_r;
  assign disp_valid = disp_valid_r;
  assign disp_data  = disp_valid_r ? doa : {WORD_W{1'b0}};

endmodule
